alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_core.sv | 77 +++++++
 rtl/alu_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: operation codes, the flag
// register layout and a small opcode classification helper.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NEG  = 4'd6,
    OP_CMP  = 4'd7,
    OP_LSL  = 4'd8,
    OP_LSLC = 4'd9,
    OP_LSR  = 4'd10,
    OP_LSRC = 4'd11,
    OP_ASR  = 4'd12,
    OP_NOP  = 4'd13
  } op_code;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
  } flags_t;

  function automatic logic is_shift(input op_code op);
    return (op == OP_LSL) || (op == OP_LSLC) || (op == OP_LSR) ||
           (op == OP_LSRC) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational ALU datapath; also produces the zero-distance
// shift result (res = rs, C cleared) so the sequencer needs no special case.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_code           op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             c_in,
  output logic [WIDTH-1:0] res,
  output flags_t           flags,
  output logic             res_we,
  output logic             flags_we
);

  // One extra bit on top holds carry or borrow for every arithmetic op.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] c_ext;

  assign c_ext = {{WIDTH{1'b0}}, c_in};

  always_comb begin
    sum      = '0;
    res_we   = 1'b0;
    flags_we = 1'b0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, rs} + {1'b0, rt};
        res_we = 1'b1; flags_we = 1'b1;
      end
      OP_ADDC: begin
        sum = {1'b0, rs} + {1'b0, rt} + c_ext;
        res_we = 1'b1; flags_we = 1'b1;
      end
      OP_SUB: begin
        sum = {1'b0, rs} - {1'b0, rt};
        res_we = 1'b1; flags_we = 1'b1;
      end
      OP_SUBC: begin
        sum = {1'b0, rs} - {1'b0, rt} - c_ext;
        res_we = 1'b1; flags_we = 1'b1;
      end
      OP_CMP: begin
        sum = {1'b0, rs} - {1'b0, rt};
        flags_we = 1'b1;
      end
      OP_AND: begin
        sum = {1'b0, rs & rt};
        res_we = 1'b1; flags_we = 1'b1;
      end
      OP_OR: begin
        sum = {1'b0, rs | rt};
        res_we = 1'b1; flags_we = 1'b1;
      end
      OP_NEG: begin
        // Top bit is the borrow of 0 - rt, i.e. set exactly when rt != 0.
        sum = {(WIDTH+1){1'b0}} - {1'b0, rt};
        res_we = 1'b1; flags_we = 1'b1;
      end
      OP_LSL, OP_LSLC, OP_LSR, OP_LSRC, OP_ASR: begin
        sum = {1'b0, rs};
        res_we = 1'b1; flags_we = 1'b1;
      end
      default: begin
        sum = '0;
      end
    endcase
  end

  assign res     = sum[WIDTH-1:0];
  assign flags.c = sum[WIDTH];
  assign flags.n = sum[WIDTH-1];
  assign flags.z = (sum[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via alu_core, multi-cycle bit-serial
// shifts via an IDLE/SHIFT FSM, with a registered result and C/N/Z flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  op_code           op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             neg_o,
  output logic             zero_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] sh_reg;
  op_code           sh_op_reg;
  logic             fill_reg;
  logic [WIDTH-1:0] result_reg;
  flags_t           flags_reg;
  logic             done_reg;

  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;
  logic             core_res_we;
  logic             core_flags_we;

  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] step_val;
  logic             step_out;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (op_i),
    .rs       (rs_i),
    .rt       (rt_i),
    .c_in     (flags_reg.c),
    .res      (core_res),
    .flags    (core_flags),
    .res_we   (core_res_we),
    .flags_we (core_flags_we)
  );

  assign accept = valid_i && (state_reg == IDLE);
  assign shamt  = (rt_i >= WIDTH_V) ? CNT_MAX : rt_i[CNT_W-1:0];

  // One shift step; ASR replicates the live MSB, the others use the latched fill.
  always_comb begin
    step_val = sh_reg;
    step_out = 1'b0;
    case (sh_op_reg)
      OP_LSL, OP_LSLC: begin
        step_out = sh_reg[WIDTH-1];
        step_val = {sh_reg[WIDTH-2:0], fill_reg};
      end
      OP_ASR: begin
        step_out = sh_reg[0];
        step_val = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
      end
      default: begin
        step_out = sh_reg[0];
        step_val = {fill_reg, sh_reg[WIDTH-1:1]};
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sh_reg     <= '0;
      sh_op_reg  <= OP_ADD;
      fill_reg   <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_shift(op_i) && (shamt != '0)) begin
              state_reg <= SHIFT;
              cnt_reg   <= shamt;
              sh_reg    <= rs_i;
              sh_op_reg <= op_i;
              fill_reg  <= ((op_i == OP_LSLC) || (op_i == OP_LSRC)) && flags_reg.c;
            end else begin
              done_reg <= 1'b1;
              if (core_res_we)   result_reg <= core_res;
              if (core_flags_we) flags_reg  <= core_flags;
            end
          end
        end
        SHIFT: begin
          // Flush wins over the final step: nothing becomes visible.
          if (flush_i) begin
            state_reg <= IDLE;
          end else begin
            sh_reg  <= step_val;
            cnt_reg <= cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) begin
              state_reg   <= IDLE;
              done_reg    <= 1'b1;
              result_reg  <= step_val;
              flags_reg.c <= step_out;
              flags_reg.n <= step_val[WIDTH-1];
              flags_reg.z <= (step_val == '0);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_reg == IDLE);
  assign done_o   = done_reg;
  assign result_o = result_reg;
  assign carry_o  = flags_reg.c;
  assign neg_o    = flags_reg.n;
  assign zero_o   = flags_reg.z;

endmodule
